ring_monitor: RTL and testbench

RING_MONITOR -- requirements
Module: ring_monitor

---
 rtl/ring_pkg.sv | 28 ++
 rtl/onehot_enc.sv | 34 +++
 rtl/ring_monitor.sv | 149 ++++++++++++++
 tb/tb_ring_monitor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring monitor: FSM states, fault codes, and rotate-left.
package ring_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2,
    S_FAULT   = 2'd3
  } ring_state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ZERO  = 2'b01;
  localparam logic [1:0] ERR_MULTI = 2'b10;
  localparam logic [1:0] ERR_ORDER = 2'b11;

  localparam int MAX_WIDTH = 16;

  // Rotate the low w bits of v left by one; bits at or above w come back zero.
  function automatic logic [MAX_WIDTH-1:0] rotl(input logic [MAX_WIDTH-1:0] v, input int w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) r[(i + 1) % w] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot classifier: binary index of the highest set bit plus
// one-hot / all-zero / multi-hot flags.
module onehot_enc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         vec,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     is_onehot,
  output logic                     is_zero,
  output logic                     is_multi
);

  localparam int IW = $clog2(WIDTH);

  logic seen_one;
  logic seen_two;

  always_comb begin
    index    = '0;
    seen_one = 1'b0;
    seen_two = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        seen_two = seen_two | seen_one;
        seen_one = 1'b1;
        index    = IW'(i);
      end
    end
    is_zero   = ~seen_one;
    is_multi  = seen_two;
    is_onehot = seen_one & ~seen_two;
  end

endmodule

// File: rtl/ring_monitor.sv
// Checks that an upstream ring counter steps left one bit per cycle and flags faults.
// Optional revolution counter enabled by defining RING_MONITOR_REV_COUNT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for a one-hot sample to start acquisition
// S_ACQUIRE | counting consecutive correct steps toward lock
// S_LOCKED  | ring stepping correctly; any violation faults
// S_FAULT   | sticky error held until Clear
module ring_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [WIDTH-1:0]         Ring_in,
  input  logic                     Clear,
  output logic [$clog2(WIDTH)-1:0] Index,
  output logic                     Index_valid,
  output logic                     Locked,
  output logic                     Error,
  output logic [1:0]               Err_code
`ifdef RING_MONITOR_REV_COUNT_EN
  ,
  output logic [7:0]               Rev_count
`endif
);

  localparam int IW = $clog2(WIDTH);

  ring_state_t          state_q, state_d;
  logic [7:0]           good_cnt_q, good_cnt_d;
  logic [1:0]           err_q, err_d;
  logic [WIDTH-1:0]     prev_q;
  logic [IW-1:0]        index_q;
  logic                 index_valid_q;

  logic [IW-1:0]        enc_index;
  logic                 is_onehot, is_zero, is_multi;
  logic [MAX_WIDTH-1:0] prev_ext, ring_ext;
  logic                 step_ok;

  onehot_enc #(.WIDTH(WIDTH)) u_enc (
    .vec       (Ring_in),
    .index     (enc_index),
    .is_onehot (is_onehot),
    .is_zero   (is_zero),
    .is_multi  (is_multi)
  );

  // Compare at full package width so the rotate helper stays width-agnostic.
  always_comb begin
    prev_ext              = '0;
    ring_ext              = '0;
    prev_ext[WIDTH-1:0]   = prev_q;
    ring_ext[WIDTH-1:0]   = Ring_in;
    step_ok               = is_onehot && (ring_ext == rotl(prev_ext, WIDTH));
  end

`ifdef RING_MONITOR_REV_COUNT_EN
  logic [7:0] rev_q, rev_d;
`endif

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_d      = err_q;
`ifdef RING_MONITOR_REV_COUNT_EN
    rev_d      = rev_q;
`endif
    if (Clear) begin
      state_d    = S_IDLE;
      good_cnt_d = '0;
      err_d      = ERR_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_onehot) begin
            state_d    = S_ACQUIRE;
            good_cnt_d = '0;
          end
        end
        S_ACQUIRE: begin
          if (!is_onehot) begin
            state_d    = S_IDLE;
            good_cnt_d = '0;
          end else if (step_ok) begin
            good_cnt_d = good_cnt_q + 8'd1;
            if (good_cnt_d == 8'(LOCK_COUNT)) state_d = S_LOCKED;
          end else begin
            good_cnt_d = '0;
          end
        end
        S_LOCKED: begin
          if (step_ok) begin
`ifdef RING_MONITOR_REV_COUNT_EN
            if (prev_q[WIDTH-1]) rev_d = rev_q + 8'd1;
`endif
          end else begin
            state_d = S_FAULT;
            if (is_zero)       err_d = ERR_ZERO;
            else if (is_multi) err_d = ERR_MULTI;
            else               err_d = ERR_ORDER;
          end
        end
        S_FAULT: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      good_cnt_q    <= '0;
      err_q         <= ERR_NONE;
      prev_q        <= '0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
`ifdef RING_MONITOR_REV_COUNT_EN
      rev_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      err_q         <= err_d;
      index_valid_q <= is_onehot;
`ifdef RING_MONITOR_REV_COUNT_EN
      rev_q         <= rev_d;
`endif
      if (is_onehot) begin
        prev_q  <= Ring_in;
        index_q <= enc_index;
      end
    end
  end

  assign Index       = index_q;
  assign Index_valid = index_valid_q;
  assign Locked      = (state_q == S_LOCKED);
  assign Error       = (state_q == S_FAULT);
  assign Err_code    = err_q;
`ifdef RING_MONITOR_REV_COUNT_EN
  assign Rev_count   = rev_q;
`endif

endmodule

// File: tb/tb_ring_monitor.sv
// Directed self-checking bench for ring_monitor (WIDTH=4, LOCK_COUNT=4).
module tb_ring_monitor;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] Ring_in;
  logic       Clear;
  logic [1:0] Index;
  logic       Index_valid;
  logic       Locked;
  logic       Error;
  logic [1:0] Err_code;
`ifdef RING_MONITOR_REV_COUNT_EN
  logic [7:0] Rev_count;
`endif

  int total = 0;
  int bad   = 0;

  ring_monitor #(.WIDTH(4), .LOCK_COUNT(4)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Ring_in     (Ring_in),
    .Clear       (Clear),
    .Index       (Index),
    .Index_valid (Index_valid),
    .Locked      (Locked),
    .Error       (Error),
    .Err_code    (Err_code)
`ifdef RING_MONITOR_REV_COUNT_EN
    ,
    .Rev_count   (Rev_count)
`endif
  );

  always #5 Clock = ~Clock;

  // Drive one sample away from the edge, then settle just after the edge.
  task automatic step(input logic [3:0] v, input logic clr, input logic rst);
    @(negedge Clock);
    Ring_in = v;
    Clear   = clr;
    Reset   = rst;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_lock();
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    // Reset held with a legal sample and Clear: reset must win over both.
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b1, 1'b1);
    total++; if (Index !== 2'd0)       begin bad++; $display("FAIL reset_index got=%0d exp=0", Index); end
    total++; if (Index_valid !== 1'b0) begin bad++; $display("FAIL reset_index_valid got=%0b exp=0", Index_valid); end
    total++; if (Locked !== 1'b0)      begin bad++; $display("FAIL reset_locked got=%0b exp=0", Locked); end
    total++; if (Error !== 1'b0)       begin bad++; $display("FAIL reset_error got=%0b exp=0", Error); end
    total++; if (Err_code !== 2'b00)   begin bad++; $display("FAIL reset_err_code got=%b exp=00", Err_code); end
`ifdef RING_MONITOR_REV_COUNT_EN
    total++; if (Rev_count !== 8'd0)   begin bad++; $display("FAIL reset_rev got=%0d exp=0", Rev_count); end
`endif
  endtask

  task automatic test_lock();
    logic [3:0] seq [5];
    logic [1:0] idx [5];
    logic       lk  [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    lk  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      step(seq[i], 1'b0, 1'b0);
      total++; if (Index !== idx[i])     begin bad++; $display("FAIL lock_index[%0d] got=%0d exp=%0d", i, Index, idx[i]); end
      total++; if (Index_valid !== 1'b1) begin bad++; $display("FAIL lock_valid[%0d] got=%0b exp=1", i, Index_valid); end
      total++; if (Locked !== lk[i])     begin bad++; $display("FAIL lock_locked[%0d] got=%0b exp=%0b", i, Locked, lk[i]); end
    end
  endtask

  task automatic test_multi_hot();
    logic [3:0] p;
    do_lock();
    step(4'b0110, 1'b0, 1'b0);
    total++; if (Error !== 1'b1)       begin bad++; $display("FAIL multi_error got=%0b exp=1", Error); end
    total++; if (Err_code !== 2'b10)   begin bad++; $display("FAIL multi_code got=%b exp=10", Err_code); end
    total++; if (Locked !== 1'b0)      begin bad++; $display("FAIL multi_locked got=%0b exp=0", Locked); end
    total++; if (Index_valid !== 1'b0) begin bad++; $display("FAIL multi_valid got=%0b exp=0", Index_valid); end
    total++; if (Index !== 2'd0)       begin bad++; $display("FAIL multi_index_hold got=%0d exp=0", Index); end
    p = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step(p, 1'b0, 1'b0);
      p = {p[2:0], p[3]};
      total++; if (Error !== 1'b1 || Err_code !== 2'b10) begin
        bad++; $display("FAIL multi_sticky[%0d] got=%0b/%b exp=1/10", i, Error, Err_code);
      end
    end
    step(4'b0001, 1'b1, 1'b0);
    total++; if (Error !== 1'b0)     begin bad++; $display("FAIL multi_clear_error got=%0b exp=0", Error); end
    total++; if (Err_code !== 2'b00) begin bad++; $display("FAIL multi_clear_code got=%b exp=00", Err_code); end
  endtask

  task automatic test_wrong_order();
    do_lock();
    step(4'b0100, 1'b0, 1'b0);
    total++; if (Error !== 1'b1 || Err_code !== 2'b11) begin
      bad++; $display("FAIL order_code got=%0b/%b exp=1/11", Error, Err_code);
    end
    total++; if (Index !== 2'd2) begin bad++; $display("FAIL order_index got=%0d exp=2", Index); end
    do_lock();
    step(4'b0000, 1'b0, 1'b0);
    total++; if (Error !== 1'b1 || Err_code !== 2'b01) begin
      bad++; $display("FAIL zero_code got=%0b/%b exp=1/01", Error, Err_code);
    end
    do_lock();
    step(4'b0001, 1'b0, 1'b0);
    total++; if (Error !== 1'b1 || Err_code !== 2'b11) begin
      bad++; $display("FAIL stall_code got=%0b/%b exp=1/11", Error, Err_code);
    end
  endtask

  task automatic test_acquire_restart();
    step(4'b0000, 1'b1, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    total++; if (Error !== 1'b0)  begin bad++; $display("FAIL acq_error got=%0b exp=0", Error); end
    total++; if (Locked !== 1'b0) begin bad++; $display("FAIL acq_locked got=%0b exp=0", Locked); end
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    total++; if (Locked !== 1'b0) begin bad++; $display("FAIL acq_early_lock got=%0b exp=0", Locked); end
    step(4'b1000, 1'b0, 1'b0);
    total++; if (Locked !== 1'b1) begin bad++; $display("FAIL acq_relock got=%0b exp=1", Locked); end
  endtask

  task automatic test_clear_violation();
    do_lock();
    step(4'b0110, 1'b1, 1'b0);
    total++; if (Error !== 1'b0 || Err_code !== 2'b00) begin
      bad++; $display("FAIL clrviol_error got=%0b/%b exp=0/00", Error, Err_code);
    end
    total++; if (Locked !== 1'b0) begin bad++; $display("FAIL clrviol_locked got=%0b exp=0", Locked); end
    // Back in IDLE: first one-hot sample only starts acquisition.
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    total++; if (Locked !== 1'b0 || Error !== 1'b0) begin
      bad++; $display("FAIL clrviol_idle got=%0b/%0b exp=0/0", Locked, Error);
    end
  endtask

  task automatic test_reset_mid();
    do_lock();
    step(4'b0110, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b1);
    total++; if (Error !== 1'b0 || Err_code !== 2'b00) begin
      bad++; $display("FAIL rstfault_error got=%0b/%b exp=0/00", Error, Err_code);
    end
    total++; if (Index_valid !== 1'b0) begin bad++; $display("FAIL rstfault_valid got=%0b exp=0", Index_valid); end
    step(4'b0001, 1'b0, 1'b0);
    do_lock();
    step(4'b0010, 1'b0, 1'b1);
    total++; if (Locked !== 1'b0) begin bad++; $display("FAIL rstlock_locked got=%0b exp=0", Locked); end
    step(4'b0010, 1'b0, 1'b0);
  endtask

`ifdef RING_MONITOR_REV_COUNT_EN
  task automatic test_revs();
    do_lock();
    total++; if (Rev_count !== 8'd0) begin bad++; $display("FAIL rev_at_lock got=%0d exp=0", Rev_count); end
    for (int r = 1; r <= 260; r++) begin
      step(4'b0010, 1'b0, 1'b0);
      step(4'b0100, 1'b0, 1'b0);
      step(4'b1000, 1'b0, 1'b0);
      step(4'b0001, 1'b0, 1'b0);
      if (r == 1) begin
        total++; if (Rev_count !== 8'd1) begin bad++; $display("FAIL rev_one got=%0d exp=1", Rev_count); end
      end
    end
    total++; if (Rev_count !== 8'd4) begin bad++; $display("FAIL rev_wrap got=%0d exp=4", Rev_count); end
    total++; if (Locked !== 1'b1)    begin bad++; $display("FAIL rev_locked got=%0b exp=1", Locked); end
    step(4'b0010, 1'b0, 1'b1);
    total++; if (Rev_count !== 8'd0 || Locked !== 1'b0) begin
      bad++; $display("FAIL rev_reset got=%0d/%0b exp=0/0", Rev_count, Locked);
    end
  endtask
`endif

  initial begin
    Reset   = 1'b1;
    Clear   = 1'b0;
    Ring_in = 4'b0000;
    test_reset();
    test_lock();
    test_multi_hot();
    test_wrong_order();
    test_acquire_restart();
    test_clear_violation();
    test_reset_mid();
`ifdef RING_MONITOR_REV_COUNT_EN
    test_revs();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
